// File: rtl/clock_set_ctrl.sv
// Time-of-day keeper with single-button hour/minute setting.
// Consumes short/long press pulses and a 1 Hz tick; drives display fields.
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 10,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       short_pression,
  input  logic       long_pression,
  input  logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);
  localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t state, state_next;
  logic [5:0] tmo;
  logic [DW-1:0] div;
  logic sp, any_press, tmo_hit, entry;
  logic sec_clr, hour_inc, min_inc, run_tick;

  // long wins over short when both arrive together
  assign sp = short_pression & ~long_pression;
  assign any_press = short_pression | long_pression;
  assign tmo_hit = (state != RUN) && tick_1hz && !any_press
                   && (tmo == TO_LAST);
  assign run_tick = (state == RUN) && tick_1hz;
  assign entry = (state_next != state);
  assign mode = state;

  always_comb begin
    state_next = state;
    sec_clr = 1'b0;
    hour_inc = 1'b0;
    min_inc = 1'b0;
    unique case (state)
      RUN: begin
        if (long_pression) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (long_pression) begin
          state_next = SET_MIN;
        end else if (sp) begin
          hour_inc = 1'b1;
        end else if (tmo_hit) begin
          state_next = RUN;
          sec_clr = 1'b1;
        end
      end
      SET_MIN: begin
        if (long_pression || tmo_hit) begin
          state_next = RUN;
          sec_clr = 1'b1;
        end else if (sp) begin
          min_inc = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state <= RUN;
    else state <= state_next;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      hour <= 5'd0;
      minute <= 6'd0;
      second <= 6'd0;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= 1'b0;
      if (sec_clr) begin
        second <= 6'd0;
      end else if (run_tick) begin
        if (second == 6'd59) begin
          second <= 6'd0;
          if (minute == 6'd59) begin
            minute <= 6'd0;
            if (hour == 5'd23) begin
              hour <= 5'd0;
              day_pulse <= 1'b1;
            end else begin
              hour <= hour + 5'd1;
            end
          end else begin
            minute <= minute + 6'd1;
          end
        end else begin
          second <= second + 6'd1;
        end
      end
      if (hour_inc)
        hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      if (min_inc)
        minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
    end
  end

  // a tick coinciding with a press is swallowed by the press
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      tmo <= 6'd0;
    end else if (entry || state == RUN || any_press) begin
      tmo <= 6'd0;
    end else if (tick_1hz) begin
      tmo <= tmo + 6'd1;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      blink <= 1'b1;
      div <= '0;
    end else if (state_next == RUN || entry || sp) begin
      blink <= 1'b1;
      div <= '0;
    end else if (div == DIV_LAST) begin
      blink <= ~blink;
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: reference model feeds a scoreboard queue,
// plus directed checks of the setting, timeout and rollover scenarios.
module tb_clock_set_ctrl;

  localparam int TO = 10;
  localparam int BD = 4;

  logic sysclk = 1'b0;
  logic rst;
  logic short_pression;
  logic long_pression;
  logic tick_1hz;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic blink;
  logic day_pulse;

  typedef struct {
    int h;
    int m;
    int s;
    int md;
    int bl;
    int dp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_h, m_m, m_s, m_md, m_bl, m_dp, m_tmo, m_bc;

  clock_set_ctrl #(
    .TIMEOUT_S(TO),
    .BLINK_DIV(BD)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .short_pression(short_pression),
    .long_pression(long_pression),
    .tick_1hz(tick_1hz),
    .hour(hour),
    .minute(minute),
    .second(second),
    .mode(mode),
    .blink(blink),
    .day_pulse(day_pulse)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_md = 0;
    m_bl = 1; m_dp = 0; m_tmo = 0; m_bc = 0;
  endtask

  task automatic enter(input int md);
    m_md = md;
    m_tmo = 0;
    m_bl = 1;
    m_bc = 0;
  endtask

  task automatic model(input logic s, input logic l, input logic t);
    logic ps;
    ps = s & ~l;
    m_dp = 0;
    if (m_md == 0) begin
      if (t) begin
        m_s++;
        if (m_s == 60) begin
          m_s = 0;
          m_m++;
          if (m_m == 60) begin
            m_m = 0;
            m_h++;
            if (m_h == 24) begin
              m_h = 0;
              m_dp = 1;
            end
          end
        end
      end
      if (l) enter(1);
    end else if (l) begin
      if (m_md == 1) begin
        enter(2);
      end else begin
        enter(0);
        m_s = 0;
      end
    end else if (ps) begin
      if (m_md == 1) m_h = (m_h + 1) % 24;
      else m_m = (m_m + 1) % 60;
      m_tmo = 0;
      m_bl = 1;
      m_bc = 0;
    end else begin
      if (m_bc == BD - 1) begin
        m_bc = 0;
        m_bl = 1 - m_bl;
      end else begin
        m_bc++;
      end
      if (t) begin
        if (m_tmo == TO - 1) begin
          enter(0);
          m_s = 0;
        end else begin
          m_tmo++;
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic l, input logic t);
    exp_t e;
    short_pression = s;
    long_pression = l;
    tick_1hz = t;
    model(s, l, t);
    e = '{h: m_h, m: m_m, s: m_s, md: m_md, bl: m_bl, dp: m_dp};
    sb.push_back(e);
    @(posedge sysclk);
    #1;
    short_pression = 1'b0;
    long_pression = 1'b0;
    tick_1hz = 1'b0;
    e = sb.pop_front();
    chk("sb_hour", int'(hour), e.h);
    chk("sb_minute", int'(minute), e.m);
    chk("sb_second", int'(second), e.s);
    chk("sb_mode", int'(mode), e.md);
    chk("sb_blink", int'(blink), e.bl);
    chk("sb_day", int'(day_pulse), e.dp);
  endtask

  initial begin
    rst = 1'b1;
    short_pression = 1'b0;
    long_pression = 1'b0;
    tick_1hz = 1'b0;
    model_reset();
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_hour", int'(hour), 0);
    chk("rst_minute", int'(minute), 0);
    chk("rst_second", int'(second), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_blink", int'(blink), 1);
    chk("rst_day", int'(day_pulse), 0);
    rst = 1'b0;

    step(0, 1, 0);
    repeat (23) step(1, 0, 0);
    step(0, 1, 0);
    repeat (59) step(1, 0, 0);
    step(0, 1, 0);
    chk("set_h23", int'(hour), 23);
    chk("set_m59", int'(minute), 59);
    repeat (59) step(0, 0, 1);
    chk("pre_roll_s", int'(second), 59);
    step(0, 0, 1);
    chk("roll_h", int'(hour), 0);
    chk("roll_m", int'(minute), 0);
    chk("roll_s", int'(second), 0);
    chk("roll_day", int'(day_pulse), 1);
    chk("roll_mode", int'(mode), 0);
    step(0, 0, 0);
    chk("roll_day_off", int'(day_pulse), 0);

    step(0, 1, 0);
    repeat (5) step(1, 0, 0);
    step(0, 1, 0);
    repeat (10) step(1, 0, 0);
    step(0, 1, 0);
    repeat (30) step(0, 0, 1);
    chk("t0510_s", int'(second), 30);
    step(0, 1, 0);
    chk("sh_mode", int'(mode), 1);
    repeat (20) step(1, 0, 0);
    chk("sh_wrap", int'(hour), 1);
    repeat (3) step(0, 0, 1);
    chk("sh_frozen_s", int'(second), 30);
    chk("sh_keep_m", int'(minute), 10);

    step(0, 1, 0);
    chk("sm_mode", int'(mode), 2);
    repeat (55) step(1, 0, 0);
    chk("sm_wrap", int'(minute), 5);
    chk("sm_keep_h", int'(hour), 1);
    step(0, 1, 0);
    chk("exit_mode", int'(mode), 0);
    chk("exit_s", int'(second), 0);
    step(0, 0, 1);
    chk("exit_tick", int'(second), 1);

    step(0, 1, 0);
    repeat (9) step(0, 0, 1);
    chk("to_hold1", int'(mode), 1);
    step(1, 0, 0);
    chk("to_short_h", int'(hour), 2);
    repeat (9) step(0, 0, 1);
    chk("to_hold2", int'(mode), 1);
    step(0, 0, 1);
    chk("to_exit", int'(mode), 0);
    chk("to_sec", int'(second), 0);

    step(0, 1, 0);
    step(1, 1, 0);
    chk("both_mode", int'(mode), 2);
    chk("both_hour", int'(hour), 2);
    step(1, 0, 1);
    chk("sht_min", int'(minute), 6);
    repeat (9) step(0, 0, 1);
    chk("sht_hold", int'(mode), 2);
    step(0, 0, 1);
    chk("sht_exit", int'(mode), 0);

    step(0, 1, 0);
    step(0, 1, 0);
    repeat (BD) step(0, 0, 0);
    chk("blink_low", int'(blink), 0);
    @(negedge sysclk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_hour", int'(hour), 0);
    chk("arst_minute", int'(minute), 0);
    chk("arst_second", int'(second), 0);
    chk("arst_mode", int'(mode), 0);
    chk("arst_blink", int'(blink), 1);
    chk("arst_day", int'(day_pulse), 0);
    @(posedge sysclk);
    #1;
    rst = 1'b0;
    step(0, 0, 1);
    chk("arst_tick", int'(second), 1);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 10 || r >= 97, r >= 90, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Consumer end of the push-button interface. Takes the one-cycle short and long press pulses produced by the button front end, and the 1 Hz tick.
- Keeps the hh:mm:ss time of day.
- Runs a setting state machine that lets the user edit hours and minutes with the single button.
- Feeds the display driver with binary time fields, the current edit mode and a blink enable for the field being edited.

Parameters:
- TIMEOUT_S, 10, number of 1 Hz ticks with no press after which a set mode auto-exits to RUN (range 1..63).
- BLINK_DIV, 25000000, sysclk cycles per blink half-period (toggle interval of blink).

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous active-high reset.
- short_pression  input  1  one-cycle pulse, short press detected.
- long_pression  input  1  one-cycle pulse, long press detected.
- tick_1hz  input  1  one-cycle pulse once per second.
- hour  output  5  hours, 0..23, binary.
- minute  output  6  minutes, 0..59, binary.
- second  output  6  seconds, 0..59, binary.
- mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; 3 never driven.
- blink  output  1  display enable for the edited field. Toggles in set modes; constant 1 in RUN.
- day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (async, while rst = 1):
  - hour = 0, minute = 0, second = 0, mode = RUN, blink = 1, day_pulse = 0.
  - Timeout and blink counters cleared.
- Reset mid-edit discards the edit; no partial state survives.
- All inputs are sampled on the rising edge. Every output changes on the edge after the triggering input cycle (latency 1). All outputs are registered.
- Press priority:
  - If short_pression and long_pression are both high in the same cycle, long wins and short is ignored.
  - Any press pulse while rst = 1 is lost.
- RUN:
  - tick_1hz increments second.
  - second 59 -> 0 carries to minute; minute 59 -> 0 carries to hour; hour 23 -> 0.
  - On the full 23:59:59 rollover, day_pulse = 1 for exactly one cycle, coincident with the fields showing 00:00:00.
  - short_pression is ignored.
  - long_pression -> SET_HOUR.
- SET_HOUR:
  - short_pression: hour += 1, wrapping 23 -> 0 with no carry into any other field.
  - long_pression -> SET_MIN.
  - tick_1hz does not advance the time (time frozen).
- SET_MIN:
  - short_pression: minute += 1, wrapping 59 -> 0, no carry into hour.
  - long_pression -> RUN, with second cleared to 0 on the same edge.
  - tick_1hz does not advance the time.
- Timeout:
  - In SET_HOUR or SET_MIN, a 6-bit counter increments on each tick_1hz and clears on any press and on every state entry.
  - When a tick arrives with the counter at TIMEOUT_S-1, go to RUN and clear second, exactly as on the SET_MIN long-press exit.
  - A press and a tick in the same cycle: the press is applied and the counter clears; that tick neither counts toward the timeout nor advances time.
- Blink:
  - On every entry into a set state, blink = 1 and the divider is cleared.
  - blink then toggles every BLINK_DIV cycles while in the set state.
  - Any short press forces blink = 1 and clears the divider, so the new value is visible immediately.
  - In RUN, blink = 1 and the divider is held at 0.
- Width rules:
  - Increments and compares are done in field width.
  - No field ever holds an out-of-range value (hour > 23 or minute/second > 59 is impossible).
  - mode is never 3.

Test Plan:
- Rollover: reset, then force the time to 23:59:59 via the set sequence (long, 23 shorts, long, 59 shorts, long), then wait 59 ticks and pulse tick_1hz -> next cycle shows 00:00:00, day_pulse high exactly 1 cycle, mode = 0.
- Set hour: in RUN at 05:10:30, long -> mode 1; 20 shorts -> hour 1 (wraps 23 -> 0); minute stays 10, second stays 30; 3 ticks during edit leave second at 30.
- Full set exit: mode 1, long -> mode 2; 55 shorts from minute 10 -> minute 5, hour unchanged; long -> mode 0, second = 0; the next tick gives second = 1.
- Timeout: TIMEOUT_S = 10; enter SET_HOUR, give 9 ticks then a short (hour +1, counter cleared), then 10 more ticks -> mode 0 on the edge after the 10th tick, second = 0.
- Simultaneous events: short and long high in the same cycle in SET_HOUR -> mode 2, hour unchanged. A tick coincident with a short in SET_MIN -> minute +1, timeout counter = 0.
- Async reset mid-edit: in SET_MIN with blink low, assert rst between clock edges -> outputs immediately 0/0/0, mode 0, blink 1, day_pulse 0; after release, the first tick gives second = 1.
